// File: rtl/l0_cache_pkg.sv
// Shared types, sizes and address helpers for the L0 cache write-side controller.
package l0_cache_pkg;
  localparam int XLEN                = 32;
  localparam int BE_W                = XLEN / 8;
  localparam int CacheIndexWidth     = 7;
  localparam int MEM_BYTE_ADDR_WIDTH = 16;
  localparam int CacheTagWidth       = MEM_BYTE_ADDR_WIDTH - CacheIndexWidth - 2;
  localparam logic [XLEN-1:0] MMIO_ADDR = 32'h4000_0000;

  typedef enum logic [1:0] {SWEEP, IDLE, DRAIN} l0_cache_writer_state_e;

  typedef struct packed {
    logic [CacheTagWidth-1:0] tag;
    logic [BE_W-1:0]          valid_bits;
  } l0_cache_entry_t;

  typedef struct packed {
    logic                       is_fill;
    logic                       mmio;
    logic [CacheIndexWidth-1:0] index;
    logic [CacheTagWidth-1:0]   tag;
    logic [XLEN-1:0]            data;
    logic [BE_W-1:0]            byte_en;
  } l0_cache_req_t;

  function automatic logic [CacheIndexWidth-1:0] get_index(input logic [XLEN-1:0] addr);
    return addr[CacheIndexWidth+1:2];
  endfunction

  function automatic logic [CacheTagWidth-1:0] get_tag(input logic [XLEN-1:0] addr);
    return addr[MEM_BYTE_ADDR_WIDTH-1:CacheIndexWidth+2];
  endfunction
endpackage

// File: rtl/l0_cache_valid_merge.sv
// Builds the tag/valid word written back for one request from the old entry.
// Store-miss allocation is enabled by defining L0_CACHE_STORE_ALLOCATE_EN.
module l0_cache_valid_merge
  import l0_cache_pkg::*;
(
  input  l0_cache_entry_t          rd_entry_i,
  input  l0_cache_entry_t          fwd_entry_i,
  input  logic                     fwd_sel_i,
  input  logic [CacheTagWidth-1:0] new_tag_i,
  input  logic [BE_W-1:0]          byte_en_i,
  input  logic                     fill_i,
  output logic                     we_o,
  output l0_cache_entry_t          entry_o,
  output logic [BE_W-1:0]          data_be_o
);
  l0_cache_entry_t old_entry;
  logic            hit;

  always_comb begin
    old_entry = fwd_sel_i ? fwd_entry_i : rd_entry_i;
    hit       = (old_entry.tag == new_tag_i) && (|old_entry.valid_bits);
    we_o      = 1'b0;
    entry_o   = old_entry;
    data_be_o = '0;
    if (fill_i) begin
      we_o               = 1'b1;
      entry_o.tag        = new_tag_i;
      entry_o.valid_bits = '1;
      data_be_o          = '1;
    end else if (hit) begin
      we_o               = 1'b1;
      entry_o.valid_bits = old_entry.valid_bits | byte_en_i;
      data_be_o          = byte_en_i;
    end else begin
`ifdef L0_CACHE_STORE_ALLOCATE_EN
      we_o               = 1'b1;
      entry_o.tag        = new_tag_i;
      entry_o.valid_bits = byte_en_i;
      data_be_o          = byte_en_i;
`else
      we_o               = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/l0_cache_writer.sv
// L0 cache write-side controller: 2-stage tag/valid read-modify-write with
// same-index forwarding, plus an invalidation sweep after reset or flush.
// Optional store-miss allocation: L0_CACHE_STORE_ALLOCATE_EN.
module l0_cache_writer
  import l0_cache_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_is_fill,
  input  logic [XLEN-1:0]            i_req_address,
  input  logic [XLEN-1:0]            i_req_data,
  input  logic [BE_W-1:0]            i_req_byte_en,
  input  logic                       i_flush_req,
  output logic                       o_flush_done,
  output logic                       o_rd_en,
  output logic [CacheIndexWidth-1:0] o_rd_index,
  input  logic [CacheTagWidth-1:0]   i_rd_tag,
  input  logic [BE_W-1:0]            i_rd_valid_bits,
  output logic                       o_wr_en,
  output logic [CacheIndexWidth-1:0] o_wr_index,
  output logic [CacheTagWidth-1:0]   o_wr_tag,
  output logic [BE_W-1:0]            o_wr_valid_bits,
  output logic [XLEN-1:0]            o_wr_data,
  output logic [BE_W-1:0]            o_wr_data_byte_en
);
  l0_cache_writer_state_e     state_q, state_d;
  logic [CacheIndexWidth-1:0] cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       s2_vld_q;
  l0_cache_req_t              s2_q;
  logic                       fwd_vld_q;
  logic [CacheIndexWidth-1:0] fwd_idx_q;
  l0_cache_entry_t            fwd_entry_q;

  logic            accept;
  logic            fwd_sel;
  logic            m_we;
  l0_cache_entry_t m_entry;
  l0_cache_entry_t rd_entry;
  logic [BE_W-1:0] m_dbe;

  assign o_req_ready  = (state_q == IDLE) && !i_flush_req;
  assign accept       = i_req_valid && o_req_ready;
  assign o_rd_en      = accept;
  assign o_rd_index   = get_index(i_req_address);
  assign o_flush_done = done_q;
  assign rd_entry     = {i_rd_tag, i_rd_valid_bits};
  // The RAM read misses a write landing in the same cycle, so take it from the register.
  assign fwd_sel      = fwd_vld_q && (fwd_idx_q == s2_q.index);

  l0_cache_valid_merge u_merge (
    .rd_entry_i  (rd_entry),
    .fwd_entry_i (fwd_entry_q),
    .fwd_sel_i   (fwd_sel),
    .new_tag_i   (s2_q.tag),
    .byte_en_i   (s2_q.byte_en),
    .fill_i      (s2_q.is_fill),
    .we_o        (m_we),
    .entry_o     (m_entry),
    .data_be_o   (m_dbe)
  );

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    done_d            = 1'b0;
    o_wr_en           = 1'b0;
    o_wr_index        = s2_q.index;
    o_wr_tag          = m_entry.tag;
    o_wr_valid_bits   = m_entry.valid_bits;
    o_wr_data         = s2_q.data;
    o_wr_data_byte_en = m_dbe;
    unique case (state_q)
      SWEEP: begin
        // Gated by reset so no write escapes while reset is held.
        o_wr_en           = i_rst_n;
        o_wr_index        = cnt_q;
        o_wr_tag          = '0;
        o_wr_valid_bits   = '0;
        o_wr_data_byte_en = '0;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        o_wr_en = s2_vld_q && !s2_q.mmio && m_we;
        if (i_flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        o_wr_en = s2_vld_q && !s2_q.mmio && m_we;
        cnt_d   = '0;
        state_d = SWEEP;
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= SWEEP;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_q        <= '0;
      fwd_vld_q   <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_entry_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      s2_vld_q    <= accept;
      if (accept) begin
        s2_q <= '{is_fill: i_req_is_fill,
                  mmio:    (i_req_address >= MMIO_ADDR),
                  index:   get_index(i_req_address),
                  tag:     get_tag(i_req_address),
                  data:    i_req_data,
                  byte_en: i_req_byte_en};
      end
      fwd_vld_q   <= o_wr_en;
      fwd_idx_q   <= o_wr_index;
      fwd_entry_q <= {o_wr_tag, o_wr_valid_bits};
    end
  end
endmodule

// File: tb/tb_l0_cache_writer.sv
// Bench for l0_cache_writer: vector table, hand sequences for sweep/flush/forwarding,
// and a random phase against an array model of the cache contents.
module tb_l0_cache_writer;
`ifdef L0_CACHE_STORE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_is_fill = 1'b0;
  logic [31:0] i_req_address = '0;
  logic [31:0] i_req_data = '0;
  logic [3:0]  i_req_byte_en = '0;
  logic        i_flush_req = 1'b0;
  logic        o_flush_done;
  logic        o_rd_en;
  logic [6:0]  o_rd_index;
  logic [6:0]  i_rd_tag;
  logic [3:0]  i_rd_valid_bits;
  logic        o_wr_en;
  logic [6:0]  o_wr_index;
  logic [6:0]  o_wr_tag;
  logic [3:0]  o_wr_valid_bits;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_data_byte_en;

  int checks = 0;
  int failures = 0;

  // Tag/valid RAM: 1-cycle read, read-old-data on a same-cycle write.
  logic       use_ram = 1'b0;
  logic [6:0] man_tag = '0;
  logic [3:0] man_val = '0;
  logic [6:0] ram_tag [128];
  logic [3:0] ram_val [128];
  logic [6:0] ram_rd_tag;
  logic [3:0] ram_rd_val;
  assign i_rd_tag        = use_ram ? ram_rd_tag : man_tag;
  assign i_rd_valid_bits = use_ram ? ram_rd_val : man_val;

  always @(posedge i_clk) begin
    if (o_rd_en) begin
      ram_rd_tag <= ram_tag[o_rd_index];
      ram_rd_val <= ram_val[o_rd_index];
    end
    if (o_wr_en) begin
      ram_tag[o_wr_index] <= o_wr_tag;
      ram_val[o_wr_index] <= o_wr_valid_bits;
    end
  end

  always #5 i_clk = ~i_clk;

  l0_cache_writer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_is_fill(i_req_is_fill), .i_req_address(i_req_address),
    .i_req_data(i_req_data), .i_req_byte_en(i_req_byte_en),
    .i_flush_req(i_flush_req), .o_flush_done(o_flush_done),
    .o_rd_en(o_rd_en), .o_rd_index(o_rd_index),
    .i_rd_tag(i_rd_tag), .i_rd_valid_bits(i_rd_valid_bits),
    .o_wr_en(o_wr_en), .o_wr_index(o_wr_index), .o_wr_tag(o_wr_tag),
    .o_wr_valid_bits(o_wr_valid_bits), .o_wr_data(o_wr_data),
    .o_wr_data_byte_en(o_wr_data_byte_en)
  );

  typedef struct {
    logic        fill;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [6:0]  rtag;
    logic [3:0]  rval;
    logic        we;
    logic [6:0]  eidx;
    logic [6:0]  etag;
    logic [3:0]  eval;
    logic [3:0]  edbe;
  } vec_t;

  typedef struct {
    logic        we;
    logic [6:0]  idx;
    logic [6:0]  tag;
    logic [3:0]  val;
    logic [3:0]  dbe;
    logic [31:0] data;
  } wr_t;

  logic [6:0] mtag [128];
  logic [3:0] mval [128];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_wr(input string nm, input wr_t w);
    chk({nm, ".we"}, 64'(o_wr_en), 64'(w.we));
    if (w.we)
      chk({nm, ".entry"},
          64'({o_wr_index, o_wr_tag, o_wr_valid_bits, o_wr_data_byte_en, o_wr_data}),
          64'({w.idx, w.tag, w.val, w.dbe, w.data}));
  endtask

  // Cache contents as seen by an ideal in-order writer.
  task automatic model_req(input logic fill, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output wr_t w);
    logic [6:0] idx, tag;
    w = '{we: 1'b0, idx: 7'h0, tag: 7'h0, val: 4'h0, dbe: 4'h0, data: data};
    if (addr >= 32'h4000_0000) return;
    idx = 7'(addr / 4);
    tag = 7'(addr / 512);
    if (fill) begin
      w.we = 1'b1; w.tag = tag; w.val = 4'hF; w.dbe = 4'hF;
    end else if (mtag[idx] == tag && mval[idx] != 4'h0) begin
      w.we = 1'b1; w.tag = mtag[idx]; w.val = mval[idx] | be; w.dbe = be;
    end else if (ALLOC) begin
      w.we = 1'b1; w.tag = tag; w.val = be; w.dbe = be;
    end
    if (w.we) begin
      w.idx = idx;
      mtag[idx] = w.tag;
      mval[idx] = w.val;
    end
  endtask

  task automatic sweep_check(input string nm, input int n, input int flush_at);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_flush_req = (i == flush_at);
      #1;
      chk(nm, 64'({o_wr_en, o_wr_index, o_wr_valid_bits, o_req_ready, o_flush_done}),
          64'({1'b1, 7'(i), 4'h0, 1'b0, 1'b0}));
    end
    i_flush_req = 1'b0;
    if (n == 128) begin
      @(negedge i_clk); #1;
      chk({nm, ".done"}, 64'({o_flush_done, o_req_ready, o_wr_en}), 64'(3'b110));
      @(negedge i_clk); #1;
      chk({nm, ".done_pulse"}, 64'(o_flush_done), 64'(0));
    end
  endtask

  task automatic drive_req(input logic fill, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    i_req_valid = 1'b1; i_req_is_fill = fill; i_req_address = addr;
    i_req_data = data; i_req_byte_en = be;
  endtask

  vec_t vecs[8];
  wr_t  pend;
  wr_t  w;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0304, 32'hDEAD_BEEF, 4'h0, 7'h00, 4'h0, 1'b1,  7'h41, 7'h01, 4'hF, 4'hF};
    vecs[1] = '{1'b0, 32'h0000_0304, 32'h00AB_0000, 4'h4, 7'h01, 4'h3, 1'b1,  7'h41, 7'h01, 4'h7, 4'h4};
    vecs[2] = '{1'b0, 32'h0000_0104, 32'h0000_0011, 4'h1, 7'h05, 4'hF, ALLOC, 7'h41, 7'h00, 4'h1, 4'h1};
    vecs[3] = '{1'b0, 32'h4000_0000, 32'h0000_0022, 4'hF, 7'h00, 4'hF, 1'b0,  7'h00, 7'h00, 4'h0, 4'h0};
    vecs[4] = '{1'b0, 32'h0000_0304, 32'h0000_3300, 4'h2, 7'h01, 4'h0, ALLOC, 7'h41, 7'h01, 4'h2, 4'h2};
    vecs[5] = '{1'b1, 32'h0000_FFFC, 32'h1234_5678, 4'h0, 7'h03, 4'h1, 1'b1,  7'h7F, 7'h7F, 4'hF, 4'hF};
    vecs[6] = '{1'b0, 32'h0000_FFFC, 32'h9900_0000, 4'h8, 7'h7F, 4'h1, 1'b1,  7'h7F, 7'h7F, 4'h9, 4'h8};
    vecs[7] = '{1'b1, 32'h4000_0004, 32'h5555_AAAA, 4'hF, 7'h7F, 4'hF, 1'b0,  7'h01, 7'h00, 4'h0, 4'h0};

    // Reset held with a request pending: nothing may issue.
    i_req_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    chk("reset_outputs", 64'({o_req_ready, o_rd_en, o_wr_en, o_flush_done}), 64'(0));
    i_req_valid = 1'b0;

    // Partial sweep, then reset mid-sweep restarts at index 0.
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    sweep_check("sweep_part", 20, -1);
    @(negedge i_clk); i_rst_n = 1'b0; #1;
    chk("reset_mid_sweep", 64'(o_wr_en), 64'(0));
    @(posedge i_clk); @(posedge i_clk); #1 i_rst_n = 1'b1;
    sweep_check("sweep_reset", 128, -1);

    // Single-request vectors with forced read data.
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      drive_req(vecs[k].fill, vecs[k].addr, vecs[k].data, vecs[k].be);
      #1;
      chk($sformatf("vec%0d.accept", k), 64'({o_req_ready, o_rd_en, o_rd_index}),
          64'({2'b11, vecs[k].eidx}));
      @(negedge i_clk);
      i_req_valid = 1'b0; man_tag = vecs[k].rtag; man_val = vecs[k].rval;
      #1;
      chk_wr($sformatf("vec%0d", k), '{we: vecs[k].we, idx: vecs[k].eidx, tag: vecs[k].etag,
             val: vecs[k].eval, dbe: vecs[k].edbe, data: vecs[k].data});
    end

    // Back-to-back store hits on one index; the second sees the first via forwarding.
    @(negedge i_clk);
    drive_req(1'b0, 32'h104, 32'h0000_AA00, 4'h2); #1;
    chk("b2b_hit.accept", 64'(o_rd_en), 64'(1));
    @(negedge i_clk);
    drive_req(1'b0, 32'h104, 32'h00BB_0000, 4'h4); man_tag = 7'h0; man_val = 4'h1; #1;
    chk_wr("b2b_hit.w1", '{1'b1, 7'h41, 7'h00, 4'h3, 4'h2, 32'h0000_AA00});
    @(negedge i_clk);
    i_req_valid = 1'b0; #1;
    chk_wr("b2b_hit.w2", '{1'b1, 7'h41, 7'h00, 4'h7, 4'h4, 32'h00BB_0000});

    // Back-to-back store misses with stale RAM data.
    @(negedge i_clk);
    drive_req(1'b0, 32'h104, 32'h0000_0001, 4'h1);
    @(negedge i_clk);
    drive_req(1'b0, 32'h104, 32'h0000_0200, 4'h2); man_tag = 7'h0; man_val = 4'h0; #1;
    chk_wr("b2b_alloc.w1", '{ALLOC, 7'h41, 7'h00, 4'h1, 4'h1, 32'h0000_0001});
    @(negedge i_clk);
    i_req_valid = 1'b0; #1;
    chk_wr("b2b_alloc.w2", '{ALLOC, 7'h41, 7'h00, 4'h3, 4'h2, 32'h0000_0200});

    // Flush against a same-cycle request with a fill in flight.
    @(negedge i_clk);
    drive_req(1'b1, 32'h304, 32'hCAFE_F00D, 4'h0);
    @(negedge i_clk);
    drive_req(1'b0, 32'h104, 32'h0000_0077, 4'h1); i_flush_req = 1'b1; #1;
    chk("flush.ready_rd", 64'({o_req_ready, o_rd_en}), 64'(0));
    chk_wr("flush.inflight", '{1'b1, 7'h41, 7'h01, 4'hF, 4'hF, 32'hCAFE_F00D});
    @(negedge i_clk);
    i_req_valid = 1'b0; i_flush_req = 1'b0; #1;
    chk("flush.drain", 64'({o_wr_en, o_req_ready, o_flush_done}), 64'(0));
    sweep_check("flush_sweep", 128, 40);

    // Random traffic against the array model; RAM is all-zero after the sweep.
    use_ram = 1'b1;
    for (int i = 0; i < 128; i++) begin mtag[i] = '0; mval[i] = '0; end
    pend = '{1'b0, 7'h0, 7'h0, 4'h0, 4'h0, 32'h0};
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] a;
      @(negedge i_clk);
      if ($urandom_range(0, 7) == 0) a = 32'h4000_0000 + 32'($urandom_range(0, 255));
      else a = {16'h0, 7'($urandom_range(0, 2)), 7'($urandom_range(0, 3) + (c % 2) * 124),
                2'($urandom)};
      drive_req(($urandom_range(0, 3) == 0), a, $urandom, 4'($urandom));
      i_req_valid = ($urandom_range(0, 3) != 0);
      #1;
      chk_wr("rand", pend);
      if (i_req_valid) begin
        chk("rand.ready", 64'(o_req_ready), 64'(1));
        model_req(i_req_is_fill, i_req_address, i_req_data, i_req_byte_en, w);
        pend = w;
      end else begin
        pend.we = 1'b0;
      end
    end
    @(negedge i_clk);
    i_req_valid = 1'b0; #1;
    chk_wr("rand.last", pend);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
